// File: rtl/spwm_pkg.sv
// Shared definitions for the SPWM modulator: sequencer state encoding and the
// carrier/sine-table defaults used by both the carrier counter and the sequencer.
package spwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int CNT_MAX  = 41;
  localparam int CNT_W    = 6;
  localparam int SINE_LEN = 64;

endpackage

// File: rtl/spwm_prescaler.sv
// Terminal-count clock divider: emits a registered one-clock tick every ratio+1
// enabled cycles. The ratio is captured on clear, so later input changes are ignored.
module spwm_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] ratio,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] ratio_q;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == ratio_q) ? '0 : cnt + 1'b1;
  end

  // tick is registered one step ahead so it is high in the cycle cnt sits at the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio_q <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
    end else if (clear) begin
      ratio_q <= ratio;
      cnt     <= '0;
      tick    <= (ratio == '0);
    end else if (en) begin
      cnt     <= cnt_nxt;
      tick    <= (cnt_nxt == ratio_q);
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/spwm_carrier_sequencer.sv
// Sequences the SPWM triangle-carrier counter: start/stop FSM, carrier direction,
// reference sample strobes and the sine-table index, with stops landing on a valley.
module spwm_carrier_sequencer
  import spwm_pkg::*;
#(
  parameter int PRESCALE_W = 8,
  parameter int IDX_W      = 6,
  parameter int SINE_LEN   = spwm_pkg::SINE_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  carryUp,
  input  logic                  carryDown,
  output logic                  cnt_e,
  output logic                  cnt_updown,
  output logic                  cnt_rst_syn,
  output logic [IDX_W-1:0]      sine_idx,
  output logic                  half_cycle,
  output logic                  sample,
  output logic                  busy,
  output logic                  done
);

  state_t state;
  logic   stop_pending;
  logic   stop_now;
  logic   idx_last;

  assign stop_now = (state == ST_RUN) && carryDown && stop_pending;
  assign idx_last = (sine_idx == IDX_W'(SINE_LEN - 1));

  // The final valley step of a stop must not be followed by another tick
  spwm_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(state == ST_ARM),
    .en   ((state == ST_RUN) && !stop_now),
    .ratio(prescale),
    .tick (cnt_e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt_updown   <= 1'b1;
      cnt_rst_syn  <= 1'b1;
      sine_idx     <= '0;
      half_cycle   <= 1'b0;
      sample       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      sample <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt_rst_syn <= 1'b1;
          if (start) begin
            state      <= ST_ARM;
            busy       <= 1'b1;
            sine_idx   <= '0;
            half_cycle <= 1'b0;
            cnt_updown <= 1'b1;
          end
        end
        ST_ARM: begin
          if (stop) stop_pending <= 1'b1;
          state       <= ST_RUN;
          cnt_rst_syn <= 1'b0;
        end
        ST_RUN: begin
          if (stop) stop_pending <= 1'b1;
          // carryDown takes priority should both flags ever arrive together
          if (carryDown) begin
            cnt_updown <= 1'b1;
            sample     <= 1'b1;
            if (stop_pending) begin
              state        <= ST_IDLE;
              done         <= 1'b1;
              busy         <= 1'b0;
              cnt_rst_syn  <= 1'b1;
              stop_pending <= 1'b0;
            end else if (idx_last) begin
              sine_idx   <= '0;
              half_cycle <= ~half_cycle;
            end else begin
              sine_idx   <= sine_idx + 1'b1;
            end
          end else if (carryUp) begin
            cnt_updown <= 1'b0;
            sample     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  carry_exclusive: assert property (@(posedge clk) disable iff (rst) !(carryUp && carryDown))
    else $error("carryUp and carryDown asserted together");

endmodule
